// File: rtl/seq_mult_unit_if.sv
// Request/response bundle for the iterative multiplier.
// The master drives operands and start; the slave returns busy/done/product.
interface seq_mult_unit_if #(
   parameter int W = 8
);
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   modport master (
      output start, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, a, b,
      output busy, done, product
   );
endinterface

// File: rtl/seq_mult_unit.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// Define SEQ_MULT_EARLY_EXIT_EN to finish once no multiplier bits remain.
module seq_mult_unit #(
   parameter int W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   seq_mult_unit_if.slave  bus
);
   localparam int CW = $clog2(W) + 1;
   localparam int PW = 2 * W;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t          state, state_n;
   logic [PW-1:0]   acc, acc_n;
   logic [PW-1:0]   mcand, mcand_n;
   logic [W-1:0]    mplier, mplier_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic            busy_q, busy_n;
   logic            done_q, done_n;
   logic [PW-1:0]   product_q, product_n;
   logic [PW-1:0]   sum;
   logic            last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         cnt       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         state     <= state_n;
         acc       <= acc_n;
         mcand     <= mcand_n;
         mplier    <= mplier_n;
         cnt       <= cnt_n;
         busy_q    <= busy_n;
         done_q    <= done_n;
         product_q <= product_n;
      end
   end

   // Product must include the add performed on the completing edge.
   always_comb begin
      sum = mplier[0] ? (acc + mcand) : acc;
`ifdef SEQ_MULT_EARLY_EXIT_EN
      last = (cnt == CW'(1)) || ((mplier >> 1) == '0);
`else
      last = (cnt == CW'(1));
`endif
   end

   always_comb begin
      state_n   = state;
      acc_n     = acc;
      mcand_n   = mcand;
      mplier_n  = mplier;
      cnt_n     = cnt;
      busy_n    = busy_q;
      done_n    = 1'b0;
      product_n = product_q;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               acc_n    = '0;
               mcand_n  = {{W{1'b0}}, bus.a};
               mplier_n = bus.b;
               cnt_n    = CW'(W);
               busy_n   = 1'b1;
               state_n  = RUN;
            end
         end
         RUN: begin
            acc_n    = sum;
            mcand_n  = mcand << 1;
            mplier_n = mplier >> 1;
            cnt_n    = cnt - CW'(1);
            if (last) begin
               product_n = sum;
               done_n    = 1'b1;
               busy_n    = 1'b0;
               state_n   = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;
endmodule

// File: tb/tb_seq_mult_unit.sv
// Randomised and directed bench for seq_mult_unit against an
// arithmetic reference model (a*b and bit-length latency).
module tb_seq_mult_unit;
   localparam int W = 8;
   localparam int LIMIT = 40;

   logic clk;
   logic rst_n;
   int   pass_cnt;
   int   total_cnt;

   seq_mult_unit_if #(.W(W)) bus ();

   seq_mult_unit #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lat_of(input logic [W-1:0] b);
`ifdef SEQ_MULT_EARLY_EXIT_EN
      int m;
      m = 0;
      for (int i = 0; i < W; i++)
         if (b[i]) m = i + 1;
      return (m == 0) ? 1 : m;
`else
      return W;
`endif
   endfunction

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      int unsigned p;
      p = int'(a) * int'(b);
      return p[2*W-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one accept: returns #1 after the accept edge, start low.
   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      tick();
      bus.start = 1'b0;
   endtask

   // Cycles until done seen; busy_bad set if busy dropped early.
   task automatic wait_done(output int n, output bit busy_bad);
      n = -1;
      busy_bad = 1'b0;
      for (int i = 1; i <= LIMIT; i++) begin
         tick();
         if (bus.done) begin
            n = i;
            break;
         end
         if (!bus.busy) busy_bad = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) tick();
      total_cnt++;
      if ({bus.busy, bus.done, bus.product} !== '0)
         $display("FAIL reset_state: got busy=%b done=%b product=%0d want 0",
                  bus.busy, bus.done, bus.product);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int n;
      bit bb;
      accept(8'd13, 8'd11);
      total_cnt++;
      if (bus.busy !== 1'b1)
         $display("FAIL basic_busy_after_accept: got %b want 1", bus.busy);
      else pass_cnt++;
      wait_done(n, bb);
      total_cnt++;
      if (n !== lat_of(8'd11))
         $display("FAIL basic_latency: got %0d want %0d", n, lat_of(8'd11));
      else pass_cnt++;
      total_cnt++;
      if (bus.product !== 16'd143 || bus.busy !== 1'b0 || bb)
         $display("FAIL basic_result: got product=%0d busy=%b early_drop=%b want 143 0 0",
                  bus.product, bus.busy, bb);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.done !== 1'b0 || bus.product !== 16'd143)
         $display("FAIL basic_done_pulse: got done=%b product=%0d want 0 143",
                  bus.done, bus.product);
      else pass_cnt++;
   endtask

   task automatic test_boundary();
      int n;
      bit bb;
      accept(8'd255, 8'd255);
      wait_done(n, bb);
      total_cnt++;
      if (bus.product !== 16'hFE01 || n !== lat_of(8'd255))
         $display("FAIL max_operands: got product=%h lat=%0d want fe01 %0d",
                  bus.product, n, lat_of(8'd255));
      else pass_cnt++;
      tick();
      accept(8'd0, 8'd200);
      wait_done(n, bb);
      total_cnt++;
      if (bus.product !== 16'd0 || n !== lat_of(8'd200))
         $display("FAIL zero_mcand: got product=%0d lat=%0d want 0 %0d",
                  bus.product, n, lat_of(8'd200));
      else pass_cnt++;
      tick();
      accept(8'd77, 8'd0);
      wait_done(n, bb);
      total_cnt++;
      if (bus.product !== 16'd0 || n !== lat_of(8'd0))
         $display("FAIL zero_mplier: got product=%0d lat=%0d want 0 %0d",
                  bus.product, n, lat_of(8'd0));
      else pass_cnt++;
      tick();
   endtask

   task automatic test_ignore_start();
      int n;
      int pulses;
      bit bb;
      accept(8'd6, 8'd7);
      tick();
      tick();
      bus.start = 1'b1;
      bus.a     = 8'd9;
      bus.b     = 8'd9;
      tick();
      bus.start = 1'b0;
      wait_done(n, bb);
      total_cnt++;
      if (bus.product !== 16'd42 || n + 3 !== lat_of(8'd7))
         $display("FAIL ignore_start: got product=%0d lat=%0d want 42 %0d",
                  bus.product, n + 3, lat_of(8'd7));
      else pass_cnt++;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.done || bus.busy) pulses++;
      end
      total_cnt++;
      if (pulses !== 0)
         $display("FAIL ignore_no_relaunch: got %0d active cycles want 0", pulses);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int n;
      bit bb;
      bus.start = 1'b1;
      bus.a     = 8'd3;
      bus.b     = 8'd5;
      tick();
      bus.a = 8'd10;
      bus.b = 8'd10;
      wait_done(n, bb);
      total_cnt++;
      if (bus.product !== 16'd15 || n !== lat_of(8'd5))
         $display("FAIL b2b_first: got product=%0d lat=%0d want 15 %0d",
                  bus.product, n, lat_of(8'd5));
      else pass_cnt++;
      tick();
      bus.start = 1'b0;
      total_cnt++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.product !== 16'd15)
         $display("FAIL b2b_relaunch: got busy=%b done=%b product=%0d want 1 0 15",
                  bus.busy, bus.done, bus.product);
      else pass_cnt++;
      wait_done(n, bb);
      total_cnt++;
      if (bus.product !== 16'd100 || n !== lat_of(8'd10) || bb)
         $display("FAIL b2b_second: got product=%0d lat=%0d want 100 %0d",
                  bus.product, n, lat_of(8'd10));
      else pass_cnt++;
      tick();
   endtask

   task automatic test_reset_mid_run();
      int pulses;
      accept(8'd50, 8'd50);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({bus.busy, bus.done, bus.product} !== '0)
         $display("FAIL midrun_reset: got busy=%b done=%b product=%0d want 0",
                  bus.busy, bus.done, bus.product);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.done || bus.busy) pulses++;
      end
      total_cnt++;
      if (pulses !== 0)
         $display("FAIL midrun_idle_after: got %0d active cycles want 0", pulses);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int n;
      bit bb;
      logic [W-1:0] a;
      logic [W-1:0] b;
      for (int k = 0; k < 30; k++) begin
         a = W'($urandom);
         b = W'($urandom);
         if (k % 7 == 3) b = W'(1) << $urandom_range(W - 1, 0);
         accept(a, b);
         bus.a = W'($urandom);
         bus.b = W'($urandom);
         wait_done(n, bb);
         total_cnt++;
         if (bus.product !== ref_mul(a, b) || n !== lat_of(b) || bb)
            $display("FAIL random_%0d: %0d*%0d got product=%0d lat=%0d want %0d %0d",
                     k, a, b, bus.product, n, ref_mul(a, b), lat_of(b));
         else pass_cnt++;
         if ($urandom_range(1, 0) == 1) tick();
      end
      tick();
   endtask

`ifdef SEQ_MULT_EARLY_EXIT_EN
   task automatic test_early_exit();
      int n;
      bit bb;
      accept(8'd100, 8'd3);
      wait_done(n, bb);
      total_cnt++;
      if (bus.product !== 16'd300 || n !== 2)
         $display("FAIL early_b3: got product=%0d lat=%0d want 300 2",
                  bus.product, n);
      else pass_cnt++;
      tick();
      accept(8'd100, 8'h80);
      wait_done(n, bb);
      total_cnt++;
      if (bus.product !== 16'd12800 || n !== 8)
         $display("FAIL early_b80: got product=%0d lat=%0d want 12800 8",
                  bus.product, n);
      else pass_cnt++;
      tick();
   endtask
`endif

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_basic();
      test_boundary();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
`ifdef SEQ_MULT_EARLY_EXIT_EN
      test_early_exit();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
